// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_if
// Description : Bundle of the writeback arbiter's bus signals.
//               Pipeline result  : pipe_valid, pipe_rd[4:0], pipe_data[63:0]
//               Long-latency     : lu_valid, lu_ready, lu_rd[4:0], lu_data[63:0]
//               Issue tracking   : issue_valid, issue_rd[4:0]
//               Hazard check     : chk_rs1/2[4:0] -> busy_rs1/2
//               Register file    : write_addr[4:0], write_data[63:0], write_ena
//               Status           : err_waw (sticky)
//               modport master : the surrounding pipeline / decode logic
//               modport slave  : the arbiter itself
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [63:0] pipe_data;

    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [63:0] lu_data;

    logic        issue_valid;
    logic [4:0]  issue_rd;

    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        busy_rs1;
    logic        busy_rs2;

    logic [4:0]  write_addr;
    logic [63:0] write_data;
    logic        write_ena;
    logic        err_waw;

    modport master (
        output pipe_valid, pipe_rd, pipe_data,
        output lu_valid, lu_rd, lu_data,
        output issue_valid, issue_rd,
        output chk_rs1, chk_rs2,
        input  lu_ready, busy_rs1, busy_rs2,
        input  write_addr, write_data, write_ena, err_waw
    );

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data,
        input  lu_valid, lu_rd, lu_data,
        input  issue_valid, issue_rd,
        input  chk_rs1, chk_rs2,
        output lu_ready, busy_rs1, busy_rs2,
        output write_addr, write_data, write_ena, err_waw
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Writeback arbiter and register scoreboard. Merges in-order
//               pipeline results with buffered long-latency results into one
//               registered register-file write stream (never to x0), and
//               tracks registers with an outstanding long-latency write.
// Ports       : clk  - clock, all state on posedge
//               rst  - synchronous active-high reset
//               bus  - wb_arbiter_if.slave (pipeline, long-latency, issue,
//                      hazard check, register-file write, err_waw)
// Parameters  : DEPTH - long-latency buffer entries (power of two, >= 2)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    wb_arbiter_if.slave bus
);

    localparam int                  C_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [C_PTR_W-1:0]  C_PTR_ONE = C_PTR_W'(1);
    localparam logic [C_PTR_W:0]    C_CNT_ONE = (C_PTR_W + 1)'(1);
    localparam logic [C_PTR_W:0]    C_CNT_MAX = (C_PTR_W + 1)'(DEPTH);

    // Buffer storage and bookkeeping
    logic [4:0]         r_fifo_rd   [DEPTH];
    logic [63:0]        r_fifo_data [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_PTR_W:0]   r_count;

    logic [31:0]        r_sb;
    logic [31:0]        w_sb_next;

    logic [4:0]         r_write_addr;
    logic [63:0]        r_write_data;
    logic               r_write_ena;
    logic               r_err_waw;

    logic               w_lu_ready;
    logic               w_pipe_wr;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic [4:0]         w_head_rd;
    logic [63:0]        w_head_data;

    assign w_lu_ready  = !rst && (r_count < C_CNT_MAX);
    assign w_pipe_wr   = bus.pipe_valid && (bus.pipe_rd != 5'd0);
    assign w_empty     = (r_count == '0);
    // A dropped x0 pipeline result leaves the write slot free for the buffer.
    assign w_pop       = !w_pipe_wr && !w_empty;
    // x0 results complete the handshake but are discarded, never stored.
    assign w_push      = bus.lu_valid && w_lu_ready && (bus.lu_rd != 5'd0);
    assign w_head_rd   = r_fifo_rd[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // Clear on pop is applied first so a same-cycle issue to the same
    // register leaves the bit set.
    always_comb begin
        w_sb_next = r_sb;
        if (w_pop) begin
            w_sb_next[w_head_rd] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            w_sb_next[bus.issue_rd] = 1'b1;
        end
        w_sb_next[0] = 1'b0;
    end

    // Buffer payload needs no reset: validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= bus.lu_rd;
            r_fifo_data[r_wr_ptr] <= bus.lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_write_addr <= '0;
            r_write_data <= '0;
            r_write_ena  <= 1'b0;
        end else if (w_pipe_wr) begin
            r_write_addr <= bus.pipe_rd;
            r_write_data <= bus.pipe_data;
            r_write_ena  <= 1'b1;
        end else if (w_pop) begin
            r_write_addr <= w_head_rd;
            r_write_data <= w_head_data;
            r_write_ena  <= 1'b1;
        end else begin
            r_write_ena  <= 1'b0;
        end
    end

    // Sticky hazard flag: the pipeline write itself still goes ahead.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_waw <= 1'b0;
        end else if (w_pipe_wr && r_sb[bus.pipe_rd]) begin
            r_err_waw <= 1'b1;
        end
    end

    assign bus.lu_ready   = w_lu_ready;
    assign bus.busy_rs1   = r_sb[bus.chk_rs1];
    assign bus.busy_rs2   = r_sb[bus.chk_rs2];
    assign bus.write_addr = r_write_addr;
    assign bus.write_data = r_write_data;
    assign bus.write_ena  = r_write_ena;
    assign bus.err_waw    = r_err_waw;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter. Directed vectors, corner
//               sequences and randomized traffic, all compared against a
//               queue-based reference model of the writeback rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [63:0] pd;
        logic        exp_we;
        logic [4:0]  exp_wa;
        logic [63:0] exp_wd;
    } vec_t;

    // Reference model state
    ent_t        m_q[$];
    logic [31:0] m_sb;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [63:0] m_wd;
    logic        m_err;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.pipe_valid  = 1'b0;
        bus.pipe_rd     = '0;
        bus.pipe_data   = '0;
        bus.lu_valid    = 1'b0;
        bus.lu_rd       = '0;
        bus.lu_data     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
    endtask

    // Applies the writeback rules to the inputs present this cycle.
    task automatic model_update();
        bit   ready;
        ent_t e;
        if (rst) begin
            m_q.delete();
            m_sb  = '0;
            m_we  = 1'b0;
            m_wa  = '0;
            m_wd  = '0;
            m_err = 1'b0;
            return;
        end
        ready = (m_q.size() < DEPTH);
        if (bus.pipe_valid && bus.pipe_rd != 0) begin
            if (m_sb[bus.pipe_rd]) m_err = 1'b1;
            m_we = 1'b1;
            m_wa = bus.pipe_rd;
            m_wd = bus.pipe_data;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_sb[e.rd] = 1'b0;
            m_we = 1'b1;
            m_wa = e.rd;
            m_wd = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (bus.lu_valid && ready && bus.lu_rd != 0) begin
            e.rd   = bus.lu_rd;
            e.data = bus.lu_data;
            m_q.push_back(e);
        end
        if (bus.issue_valid && bus.issue_rd != 0) m_sb[bus.issue_rd] = 1'b1;
    endtask

    // One clock: check combinational outputs, advance model, check registers.
    task automatic step();
        bit was_rst;
        #1;
        check("lu_ready", bus.lu_ready, (!rst && m_q.size() < DEPTH) ? 1 : 0);
        check("busy_rs1", bus.busy_rs1, m_sb[bus.chk_rs1]);
        check("busy_rs2", bus.busy_rs2, m_sb[bus.chk_rs2]);
        was_rst = rst;
        model_update();
        @(posedge clk);
        #1;
        check("write_ena", bus.write_ena, m_we);
        if (m_we || was_rst) begin
            check("write_addr", bus.write_addr, m_wa);
            check("write_data", bus.write_data, m_wd);
        end
        check("err_waw", bus.err_waw, m_err);
        if (bus.write_ena && bus.write_addr == 0) check("write_x0", 1, 0);
    endtask

    task automatic busy_sweep(input string name);
        for (int r = 0; r < 32; r++) begin
            bus.chk_rs1 = 5'(r);
            bus.chk_rs2 = 5'(31 - r);
            #0.1;
            check({name, "_rs1"}, bus.busy_rs1, 0);
            check({name, "_rs2"}, bus.busy_rs2, 0);
        end
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF,            1'b1, 5'd5,  64'hDEAD_BEEF};
        vecs[1] = '{1'b1, 5'd0,  64'hCAFE,                 1'b0, 5'd0,  64'h0};
        vecs[2] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF,  1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{1'b0, 5'd12, 64'h55,                   1'b0, 5'd0,  64'h0};
        vecs[4] = '{1'b1, 5'd1,  64'h0123_4567_89AB_CDEF,  1'b1, 5'd1,  64'h0123_4567_89AB_CDEF};

        // ---------------- reset and idle ----------------
        idle();
        bus.chk_rs1 = '0;
        bus.chk_rs2 = '0;
        rst = 1'b1;
        m_q.delete();
        m_sb = '0; m_we = 0; m_wa = 0; m_wd = 0; m_err = 0;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        step();
        check("idle_write_ena", bus.write_ena, 0);
        check("idle_lu_ready", bus.lu_ready, 1);
        check("idle_err_waw", bus.err_waw, 0);
        busy_sweep("idle_busy");

        // ---------------- directed pipeline vectors ----------------
        for (int i = 0; i < 5; i++) begin
            idle();
            bus.pipe_valid = vecs[i].pv;
            bus.pipe_rd    = vecs[i].prd;
            bus.pipe_data  = vecs[i].pd;
            step();
            check($sformatf("vec%0d_we", i), bus.write_ena, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d_wa", i), bus.write_addr, vecs[i].exp_wa);
                check($sformatf("vec%0d_wd", i), bus.write_data, vecs[i].exp_wd);
            end
        end

        // ---------------- long-latency result behind pipe writes ----------------
        idle();
        bus.chk_rs1 = 5'd7;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_data = 64'h31;
        step();
        check("x7_busy_a", bus.busy_rs1, 1);
        check("x7_wr1", bus.write_addr, 3);
        idle();
        bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_data = 64'h1234;
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_data = 64'h32;
        step();
        check("x7_busy_b", bus.busy_rs1, 1);
        check("x7_wr2", bus.write_addr, 3);
        idle();
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_data = 64'h33;
        step();
        check("x7_busy_c", bus.busy_rs1, 1);
        check("x7_wr3", bus.write_data, 64'h33);
        idle();
        step();
        check("x7_we", bus.write_ena, 1);
        check("x7_wa", bus.write_addr, 7);
        check("x7_wd", bus.write_data, 64'h1234);
        check("x7_busy_clr", bus.busy_rs1, 0);
        step();
        check("x7_drained", bus.write_ena, 0);

        // ---------------- fill / drain with pointer wrap ----------------
        for (int rep = 0; rep < 4; rep++) begin
            idle();
            bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd2; bus.pipe_data = 64'(rep);
            bus.lu_valid = 1'b1; bus.lu_rd = 5'(10 + rep); bus.lu_data = 64'hA000 + 64'(rep);
            step();
            bus.lu_rd = 5'(20 + rep); bus.lu_data = 64'hB000 + 64'(rep);
            step();
            bus.lu_valid = 1'b0;
            step();
            check("fill_lu_ready", bus.lu_ready, 0);
            idle();
            step();
            check("drain1_wa", bus.write_addr, 10 + rep);
            check("drain1_wd", bus.write_data, 64'hA000 + 64'(rep));
            check("drain1_ready", bus.lu_ready, 1);
            step();
            check("drain2_wa", bus.write_addr, 20 + rep);
            check("drain2_wd", bus.write_data, 64'hB000 + 64'(rep));
        end

        // ---------------- set wins over pop-clear, then WAW error ----------------
        idle();
        bus.chk_rs1 = 5'd9;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        step();
        idle();
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd4; bus.pipe_data = 64'h44;
        bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_data = 64'h99;
        step();
        idle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        step();
        check("x9_pop_wa", bus.write_addr, 9);
        check("x9_busy_kept", bus.busy_rs1, 1);
        check("x9_no_err_yet", bus.err_waw, 0);
        idle();
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd9; bus.pipe_data = 64'h999;
        step();
        check("waw_set", bus.err_waw, 1);
        check("waw_write_proceeds", bus.write_data, 64'h999);
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            check("waw_sticky", bus.err_waw, 1);
        end

        // ---------------- reset mid-operation ----------------
        idle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd1; bus.pipe_data = 64'h1;
        bus.lu_valid = 1'b1; bus.lu_rd = 5'd4; bus.lu_data = 64'h4;
        step();
        bus.issue_rd = 5'd5; bus.lu_rd = 5'd5; bus.lu_data = 64'h5;
        step();
        bus.issue_rd = 5'd6; bus.lu_valid = 1'b0;
        step();
        bus.chk_rs1 = 5'd6;
        #0.1;
        check("pre_rst_busy6", bus.busy_rs1, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        check("rst_we", bus.write_ena, 0);
        check("rst_err", bus.err_waw, 0);
        busy_sweep("rst_busy");
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_stale_write", bus.write_ena, 0);
        end

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 199) == 0);
            bus.pipe_valid  = ($urandom_range(0, 1) == 1);
            bus.pipe_rd     = 5'($urandom_range(0, 31));
            bus.pipe_data   = {32'($urandom), 32'($urandom)};
            bus.lu_valid    = ($urandom_range(0, 2) != 0);
            bus.lu_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.lu_data     = {32'($urandom), 32'($urandom)};
            bus.issue_valid = ($urandom_range(0, 2) == 0);
            bus.issue_rd    = 5'($urandom_range(0, 31));
            bus.chk_rs1     = 5'($urandom_range(0, 31));
            bus.chk_rs2     = 5'($urandom_range(0, 31));
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and register scoreboard sitting between the execute/memory pipeline and the 32×64 integer register file write port. Merges single-cycle in-order pipeline results with out-of-order results from the long-latency unit (mul/div/load miss) into one registered write stream. Never issues a write to x0. Tracks which architectural registers have an outstanding long-latency write so decode can stall on RAW/WAW hazards.

## Interface
- DEPTH, 2: long-latency result buffer entries (power of two, ≥2)
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- pipe_valid  in  1  pipeline result this cycle; always accepted, no backpressure
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  64  pipeline result
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  buffer can accept; transfer when lu_valid && lu_ready
- lu_rd  in  5  long-latency destination register
- lu_data  in  64  long-latency result
- issue_valid  in  1  a long-latency op was dispatched this cycle
- issue_rd  in  5  its destination register
- chk_rs1, chk_rs2  in  5 each  decode source registers to check
- busy_rs1, busy_rs2  out  1 each  combinational: scoreboard bit of chk_rsN (x0 always 0)
- write_addr  out  5  to register file
- write_data  out  64  to register file
- write_ena  out  1  to register file; never high with write_addr == 0
- err_waw  out  1  sticky: pipeline wrote a scoreboard-busy register

## Operation
- Buffer: DEPTH-entry FIFO of {rd, data}, circular read/write pointers plus count. lu_ready = !rst && count < DEPTH (combinational, not dependent on lu_valid). Push on lu_valid && lu_ready.
- Output select each cycle, priority order:
  - pipe_valid && pipe_rd != 0 → pipeline result to output register.
  - else FIFO non-empty → pop head to output register.
  - else write_ena ← 0.
- pipe_valid with pipe_rd == 0: dropped, does not block FIFO pop that cycle.
- Long-latency result with lu_rd == 0: accepted (handshake completes), never pushed, no write.
- Scoreboard: 32 bits, bit 0 hardwired 0.
  - Set bit issue_rd on issue_valid (issue_rd != 0).
  - Clear bit rd when its FIFO entry is popped.
  - Same register set and cleared in one cycle: set wins.
- err_waw set when pipe_valid && pipe_rd != 0 && scoreboard[pipe_rd]; cleared only by rst. The pipeline write still proceeds.
- FIFO push and pop in the same cycle: count unchanged; full FIFO does not accept (lu_ready already 0).
- Pointer wrap modulo DEPTH.

## Timing
- Reset (rst high at posedge): FIFO empty, pointers/count 0, scoreboard 0, write_addr 0, write_data 0, write_ena 0, err_waw 0; lu_ready 0 while rst high.
- Pipeline latency: pipe_valid at edge N → write_ena/addr/data valid in cycle N+1 (one register).
- Long-latency latency: accepted at edge N, FIFO empty, no pipe write at N+1 → written cycle N+2.
- Scoreboard bit clears at the pop edge. In the cycle write_ena is high, busy is already 0; the register file commits at that cycle's negedge, so decode reads the new value in that same cycle.
- busy_rsN is purely combinational from scoreboard state: no issue-to-busy bypass. A register issued at edge N reads busy from cycle N+1.
- rst mid-operation discards buffered and pending results. Scoreboard clears; no write is issued from pre-reset state.

## Test plan
- Reset then idle: write_ena = 0, lu_ready = 1, busy_rs1/2 = 0 for all 32 checks, err_waw = 0.
- pipe_valid, rd = 5, data 0xDEAD_BEEF → next cycle write_ena = 1, addr 5, data 0xDEAD_BEEF. Same with rd = 0 → write_ena stays 0.
- Issue rd = 7; lu result rd = 7 data 0x1234 while pipe writes rd = 3 for 3 cycles:
  - busy_rs1(7) = 1 until pop.
  - Writes occur in order: x3, x3, x3, then x7 = 0x1234.
  - busy clears in the x7 write cycle.
- Fill FIFO with 2 results under continuous pipe writes → lu_ready = 0. Release the pipe → entries drain FIFO order, lu_ready = 1 after first pop. Repeat ≥3 times to cover pointer wrap.
- Issue rd = 9 in the same cycle a buffered rd = 9 pops → scoreboard[9] = 1 afterward. Pipe write to rd = 9 → err_waw = 1 and stays 1 until rst.
- Assert rst with 2 FIFO entries and 3 busy bits → write_ena = 0 after reset, no stale writes, all busy = 0.
